// File: rtl/rsnn_step_sequencer.sv
// ============================================================================
//  Module      : rsnn_step_sequencer
//  Description : Time-step scheduler for the recurrent spiking core. Walks the
//                neurons through one shared update datapath over req/ack and
//                commits the collected spike vector at the end of each step.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rsnn_step_sequencer #(
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = 3,
    parameter int TS_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N_NEURONS-1:0] in_spikes,
    output logic                 busy,
    output logic                 upd_req,
    output logic [IDX_W-1:0]     nrn_idx,
    input  logic                 upd_ack,
    input  logic                 upd_spike,
    output logic [N_NEURONS-1:0] in_spk_q,
    output logic [N_NEURONS-1:0] rec_spk_q,
    output logic [N_NEURONS-1:0] spikes_out,
    output logic                 step_done,
    output logic [TS_W-1:0]      step_cnt
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_REQ    = 2'd1;
    localparam logic [1:0] C_ST_COMMIT = 2'd2;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_NEURONS - 1);

    logic [1:0]           r_state;
    logic [N_NEURONS-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= C_ST_IDLE;
            r_acc      <= '0;
            busy       <= 1'b0;
            upd_req    <= 1'b0;
            nrn_idx    <= '0;
            in_spk_q   <= '0;
            rec_spk_q  <= '0;
            spikes_out <= '0;
            step_done  <= 1'b0;
            step_cnt   <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    step_done <= 1'b0;
                    if (start) begin
                        in_spk_q <= in_spikes;
                        nrn_idx  <= '0;
                        r_acc    <= '0;
                        busy     <= 1'b1;
                        upd_req  <= 1'b1;
                        r_state  <= C_ST_REQ;
                    end
                end

                // upd_req stays high across transfers so back-to-back acks
                // retire one neuron per cycle; without an ack everything holds.
                C_ST_REQ: begin
                    if (upd_ack) begin
                        r_acc[nrn_idx] <= upd_spike;
                        if (nrn_idx == C_LAST_IDX) begin
                            upd_req <= 1'b0;
                            r_state <= C_ST_COMMIT;
                        end else begin
                            nrn_idx <= nrn_idx + IDX_W'(1);
                        end
                    end
                end

                C_ST_COMMIT: begin
                    spikes_out <= r_acc;
                    rec_spk_q  <= r_acc;
                    step_cnt   <= step_cnt + TS_W'(1);
                    step_done  <= 1'b1;
                    busy       <= 1'b0;
                    r_state    <= C_ST_IDLE;
                end

                default: begin
                    r_state <= C_ST_IDLE;
                    upd_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rsnn_step_sequencer.sv
// ============================================================================
//  Module      : tb_rsnn_step_sequencer
//  Description : Directed self-checking bench for rsnn_step_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rsnn_step_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] in_spikes;
    logic       busy;
    logic       upd_req;
    logic [2:0] nrn_idx;
    logic       upd_ack;
    logic       upd_spike;
    logic [7:0] in_spk_q;
    logic [7:0] rec_spk_q;
    logic [7:0] spikes_out;
    logic       step_done;
    logic [7:0] step_cnt;

    int         n_checks;
    int         n_pass;
    int         done_cnt;
    logic [7:0] exp_prev;
    logic [7:0] exp_cnt;

    rsnn_step_sequencer #(
        .N_NEURONS (8),
        .IDX_W     (3),
        .TS_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_spikes  (in_spikes),
        .busy       (busy),
        .upd_req    (upd_req),
        .nrn_idx    (nrn_idx),
        .upd_ack    (upd_ack),
        .upd_spike  (upd_spike),
        .in_spk_q   (in_spk_q),
        .rec_spk_q  (rec_spk_q),
        .spikes_out (spikes_out),
        .step_done  (step_done),
        .step_cnt   (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (step_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy),       32'h0);
        check({tag, "_req"},   32'(upd_req),    32'h0);
        check({tag, "_idx"},   32'(nrn_idx),    32'h0);
        check({tag, "_inq"},   32'(in_spk_q),   32'h0);
        check({tag, "_rec"},   32'(rec_spk_q),  32'h0);
        check({tag, "_out"},   32'(spikes_out), 32'h0);
        check({tag, "_done"},  32'(step_done),  32'h0);
        check({tag, "_cnt"},   32'(step_cnt),   32'h0);
    endtask

    // One full step: neuron i reports pat[i]; optional random ack gaps and
    // noisy start/in_spikes while the step is in flight.
    task automatic run_step(input logic [7:0] ins, input logic [7:0] pat,
                            input int max_gap, input bit noise);
        int d0;
        d0        = done_cnt;
        in_spikes = ins;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("st_busy", 32'(busy),     32'h1);
        check("st_req",  32'(upd_req),  32'h1);
        check("st_inq",  32'(in_spk_q), 32'(ins));
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                upd_ack   = 1'b0;
                upd_spike = 1'b1;
                if (noise) begin
                    start     = 1'b1;
                    in_spikes = 8'($urandom);
                end
                tick();
                check("gap_idx", 32'(nrn_idx), 32'(i));
                check("gap_req", 32'(upd_req), 32'h1);
            end
            if (noise) begin
                start     = 1'b1;
                in_spikes = ~ins;
            end
            check("idx",     32'(nrn_idx),    32'(i));
            check("req",     32'(upd_req),    32'h1);
            check("rec_mid", 32'(rec_spk_q),  32'(exp_prev));
            check("out_mid", 32'(spikes_out), 32'(exp_prev));
            upd_ack   = 1'b1;
            upd_spike = pat[i];
            tick();
            upd_ack   = 1'b0;
            upd_spike = 1'b0;
        end
        check("commit_req",  32'(upd_req),   32'h0);
        check("commit_done", 32'(step_done), 32'h0);
        check("commit_busy", 32'(busy),      32'h1);
        tick();
        start    = 1'b0;
        exp_prev = pat;
        exp_cnt  = exp_cnt + 8'd1;
        check("done",     32'(step_done),  32'h1);
        check("done_bsy", 32'(busy),       32'h0);
        check("out",      32'(spikes_out), 32'(pat));
        check("rec",      32'(rec_spk_q),  32'(pat));
        check("cnt",      32'(step_cnt),   32'(exp_cnt));
        check("inq_hold", 32'(in_spk_q),   32'(ins));
        tick();
        check("done_lo",  32'(step_done),  32'h0);
        check("idle_bsy", 32'(busy),       32'h0);
        check("pulses",   32'(done_cnt - d0), 32'h1);
    endtask

    initial begin
        int d0;
        n_checks  = 0;
        n_pass    = 0;
        done_cnt  = 0;
        exp_prev  = 8'h00;
        exp_cnt   = 8'h00;
        reset     = 1'b1;
        start     = 1'b0;
        in_spikes = 8'h00;
        upd_ack   = 1'b0;
        upd_spike = 1'b0;

        // T1: reset held with random inputs
        for (int c = 0; c < 2; c++) begin
            start     = 1'($urandom);
            in_spikes = 8'($urandom);
            upd_ack   = 1'($urandom);
            upd_spike = 1'($urandom);
            tick();
        end
        check_all_zero("t1");
        reset = 1'b0; start = 1'b0; upd_ack = 1'b0; upd_spike = 1'b0;
        tick();
        check_all_zero("t1_idle");

        // T2: single step, spike = nrn_idx[0]
        run_step(8'h5C, 8'hAA, 0, 1'b0);

        // T3: random ack gaps, spikes on neurons 0 and 7
        run_step(8'h13, 8'h81, 3, 1'b0);

        // T4: ack while idle is ignored, then a step with noisy inputs
        d0 = done_cnt;
        upd_ack = 1'b1; upd_spike = 1'b1;
        tick(); tick();
        check("t4_idle_req",  32'(upd_req), 32'h0);
        check("t4_idle_busy", 32'(busy),    32'h0);
        check("t4_idle_idx",  32'(nrn_idx), 32'h7);
        upd_ack = 1'b0; upd_spike = 1'b0;
        run_step(8'h3C, 8'h66, 2, 1'b1);
        tick(); tick();
        check("t4_busy",  32'(busy),           32'h0);
        check("t4_cnt",   32'(step_cnt),       32'(exp_cnt));
        check("t4_steps", 32'(done_cnt - d0),  32'h1);

        // T5: reset mid-step at nrn_idx=4 after a step that gave 8'hAA
        run_step(8'hF0, 8'hAA, 0, 1'b0);
        d0 = done_cnt;
        in_spikes = 8'h77; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            upd_ack = 1'b1; upd_spike = 1'b1;
            tick();
        end
        upd_ack = 1'b0;
        check("t5_idx4", 32'(nrn_idx), 32'h4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("t5");
        tick();
        check("t5_nodone", 32'(done_cnt - d0), 32'h0);
        check("t5_req",    32'(upd_req),       32'h0);
        exp_prev = 8'h00;
        exp_cnt  = 8'h00;
        run_step(8'h01, 8'h42, 1, 1'b0);

        // T6: 256 back-to-back steps wrap the counter
        d0 = done_cnt;
        for (int s = 0; s < 256; s++) begin
            run_step(8'($urandom), 8'($urandom), 0, 1'b0);
        end
        check("t6_cnt",   32'(step_cnt),      32'h1);
        check("t6_steps", 32'(done_cnt - d0), 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
